// File: rtl/pong_match_ctrl_pkg.sv
// Shared types for the Pong match sequencer: state encodings, serve directions, score helper.
// Latency: none (types and pure functions only).
// Backpressure: none.
package pong_match_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_POINT = 3'd4,
        ST_OVER  = 3'd5
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // BCD digit increment that sticks at the winning score, so a digit never passes 9
    function automatic logic [3:0] bcd_inc_sat(input logic [3:0] v, input logic [3:0] lim);
        return (v >= lim) ? lim : v + 4'd1;
    endfunction

endpackage

// File: rtl/pong_match_ctrl_btn_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, frame-tick debounce, one-clk pulse on debounced rise.
// Latency: 2 clk sync + DEBOUNCE_TICKS differing frame-tick samples, pulse registered on the accepting edge.
// Backpressure: none; pulse is fire-and-forget.
module btn_debounce #(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic frame_tick,
    input  logic btn_raw,
    output logic btn_pulse
);

    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    // Bring the raw button into the clock domain before anything looks at it
    always_ff @(posedge clk) begin
        if (clr) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after enough consecutive frame samples disagree with the current one
    always_ff @(posedge clk) begin
        if (clr) begin
            level     <= 1'b0;
            cnt       <= '0;
            btn_pulse <= 1'b0;
        end else begin
            btn_pulse <= 1'b0;
            if (frame_tick) begin
                if (sync2 == level) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    cnt       <= '0;
                    level     <= sync2;
                    btn_pulse <= sync2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: start/pause gating, serve/point timing, BCD scoring, game-over detection.
// Latency: miss or start pulse updates state/score/ball_reset at the next posedge; ball_run tracks next state.
// Backpressure: none; miss and start inputs are single-cycle pulses consumed when seen.
module pong_match_ctrl
    import pong_match_ctrl_pkg::*;
#(
    parameter int WIN_SCORE      = 9,
    parameter int SERVE_TICKS    = 60,
    parameter int POINT_TICKS    = 90,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       frame_tick,
    input  logic       btn_start,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       ball_run,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic       game_over,
    output logic [2:0] state_o
);

    localparam int MAX_TICKS = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_TICKS - 1);
    localparam logic [CNT_W-1:0] POINT_LAST = CNT_W'(POINT_TICKS - 1);
    localparam logic [3:0]       WIN_BCD    = 4'(WIN_SCORE);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic               start_pulse;
    logic               miss_any;
    logic               left_pt;
    logic               right_pt;
    logic [3:0]         left_inc;
    logic [3:0]         right_inc;

    btn_debounce #(
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) u_btn_start (
        .clk        (clk),
        .clr        (clr),
        .frame_tick (frame_tick),
        .btn_raw    (btn_start),
        .btn_pulse  (start_pulse)
    );

    // A simultaneous double miss is a wash: nobody scores
    assign miss_any  = miss_left | miss_right;
    assign left_pt   = miss_right & ~miss_left;
    assign right_pt  = miss_left & ~miss_right;
    assign left_inc  = bcd_inc_sat(score_left, WIN_BCD);
    assign right_inc = bcd_inc_sat(score_right, WIN_BCD);

    // State register
    always_ff @(posedge clk) begin
        if (clr) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state decode; a miss outranks a same-cycle start press in PLAY
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start_pulse) state_next = ST_SERVE;
            ST_SERVE: if (frame_tick && cnt == SERVE_LAST) state_next = ST_PLAY;
            ST_PLAY: begin
                if (miss_any) begin
                    if ((left_pt && left_inc == WIN_BCD) || (right_pt && right_inc == WIN_BCD))
                        state_next = ST_OVER;
                    else
                        state_next = ST_POINT;
                end else if (start_pulse) begin
                    state_next = ST_PAUSE;
                end
            end
            ST_PAUSE: if (start_pulse) state_next = ST_PLAY;
            ST_POINT: if (frame_tick && cnt == POINT_LAST) state_next = ST_SERVE;
            ST_OVER:  if (start_pulse) state_next = ST_SERVE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Status outputs decoded straight from the current state
    always_comb begin
        game_over = (state == ST_OVER);
        state_o   = state;
    end

    // Tick counter, scores and ball control registers
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt         <= '0;
            score_left  <= 4'd0;
            score_right <= 4'd0;
            ball_run    <= 1'b0;
            ball_reset  <= 1'b0;
            serve_dir   <= DIR_LEFT;
        end else begin
            ball_run   <= (state_next == ST_PLAY);
            ball_reset <= 1'b0;

            if (state_next != state)
                cnt <= '0;
            else if (frame_tick && (state == ST_SERVE || state == ST_POINT))
                cnt <= cnt + 1'b1;

            case (state)
                ST_IDLE, ST_OVER: begin
                    if (start_pulse) begin
                        score_left  <= 4'd0;
                        score_right <= 4'd0;
                        ball_reset  <= 1'b1;
                        serve_dir   <= DIR_LEFT;
                    end
                end
                ST_PLAY: begin
                    if (miss_any) ball_reset <= 1'b1;
                    if (left_pt) begin
                        score_left <= left_inc;
                        serve_dir  <= DIR_RIGHT;
                    end
                    if (right_pt) begin
                        score_right <= right_inc;
                        serve_dir   <= DIR_LEFT;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl: per-cycle vector table for reset/debounce/start, then match sequences.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: none.
module tb_pong_match_ctrl;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       frame_tick = 1'b0;
    logic       btn_start = 1'b0;
    logic       miss_left = 1'b0;
    logic       miss_right = 1'b0;
    logic       ball_run;
    logic       ball_reset;
    logic       serve_dir;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic       game_over;
    logic [2:0] state_o;

    int n_cmp = 0;
    int n_err = 0;

    localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_PAUSE = 3, S_POINT = 4, S_OVER = 5;

    typedef struct {
        logic       clr;
        logic       ft;
        logic       btn;
        logic       ml;
        logic       mr;
        logic [2:0] st;
        logic       run;
        logic       rst;
        logic       dir;
        logic [3:0] sl;
        logic [3:0] sr;
        logic       go;
    } vec_t;

    vec_t tbl [9];

    pong_match_ctrl dut (
        .clk         (clk),
        .clr         (clr),
        .frame_tick  (frame_tick),
        .btn_start   (btn_start),
        .miss_left   (miss_left),
        .miss_right  (miss_right),
        .ball_run    (ball_run),
        .ball_reset  (ball_reset),
        .serve_dir   (serve_dir),
        .score_left  (score_left),
        .score_right (score_right),
        .game_over   (game_over),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic ft);
        frame_tick = ft;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            cycle(1'b1);
            cycle(1'b0);
        end
    endtask

    task automatic miss(input logic l, input logic r);
        miss_left  = l;
        miss_right = r;
        cycle(1'b0);
        miss_left  = 1'b0;
        miss_right = 1'b0;
    endtask

    task automatic to_play_from_point();
        frames(89);
        chk("point_hold", int'(state_o), S_POINT);
        cycle(1'b1);
        chk("point_to_serve", int'(state_o), S_SERVE);
        frames(59);
        chk("serve_hold", int'(state_o), S_SERVE);
        cycle(1'b1);
        chk("serve_to_play", int'(state_o), S_PLAY);
        chk("serve_to_play_run", int'(ball_run), 1);
    endtask

    initial begin
        // clr, ft, btn, ml, mr | state, run, rst, dir, sl, sr, go
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0};

        #2;
        // Reset, stray misses in IDLE, start press debounced over four differing samples
        for (int i = 0; i < 9; i++) begin
            clr        = tbl[i].clr;
            btn_start  = tbl[i].btn;
            miss_left  = tbl[i].ml;
            miss_right = tbl[i].mr;
            cycle(tbl[i].ft);
            chk($sformatf("v%0d_state", i), int'(state_o), int'(tbl[i].st));
            chk($sformatf("v%0d_run", i), int'(ball_run), int'(tbl[i].run));
            chk($sformatf("v%0d_reset", i), int'(ball_reset), int'(tbl[i].rst));
            chk($sformatf("v%0d_dir", i), int'(serve_dir), int'(tbl[i].dir));
            chk($sformatf("v%0d_sl", i), int'(score_left), int'(tbl[i].sl));
            chk($sformatf("v%0d_sr", i), int'(score_right), int'(tbl[i].sr));
            chk($sformatf("v%0d_go", i), int'(game_over), int'(tbl[i].go));
        end
        miss_left  = 1'b0;
        miss_right = 1'b0;

        // SERVE holds for 60 frame ticks, button released meanwhile
        frames(59);
        chk("serve_59", int'(state_o), S_SERVE);
        chk("serve_59_run", int'(ball_run), 0);
        cycle(1'b1);
        chk("serve_60", int'(state_o), S_PLAY);
        chk("serve_60_run", int'(ball_run), 1);

        // Bounce 1-0-1 across three ticks must not produce a start pulse
        btn_start = 1'b1; frames(1);
        btn_start = 1'b0; frames(1);
        btn_start = 1'b1; frames(1);
        btn_start = 1'b0; frames(6);
        chk("bounce_state", int'(state_o), S_PLAY);
        chk("bounce_run", int'(ball_run), 1);

        // Right paddle misses: left scores, serve goes right
        miss(1'b0, 1'b1);
        chk("pt1_state", int'(state_o), S_POINT);
        chk("pt1_sl", int'(score_left), 1);
        chk("pt1_dir", int'(serve_dir), 1);
        chk("pt1_reset", int'(ball_reset), 1);
        chk("pt1_run", int'(ball_run), 0);
        to_play_from_point();
        chk("pt1_reset_gone", int'(ball_reset), 0);

        // Double miss: no score, direction kept
        miss(1'b1, 1'b1);
        chk("dbl_state", int'(state_o), S_POINT);
        chk("dbl_sl", int'(score_left), 1);
        chk("dbl_sr", int'(score_right), 0);
        chk("dbl_dir", int'(serve_dir), 1);
        chk("dbl_reset", int'(ball_reset), 1);
        to_play_from_point();

        // Walk left score up to 8
        for (int i = 0; i < 7; i++) begin
            miss(1'b0, 1'b1);
            chk($sformatf("walk%0d_sl", i), int'(score_left), 2 + i);
            chk($sformatf("walk%0d_state", i), int'(state_o), S_POINT);
            to_play_from_point();
        end

        // Ninth point ends the match
        miss(1'b0, 1'b1);
        chk("win_sl", int'(score_left), 9);
        chk("win_state", int'(state_o), S_OVER);
        chk("win_go", int'(game_over), 1);
        chk("win_run", int'(ball_run), 0);
        miss(1'b1, 1'b0);
        frames(3);
        miss(1'b0, 1'b1);
        chk("over_sl", int'(score_left), 9);
        chk("over_sr", int'(score_right), 0);
        chk("over_state", int'(state_o), S_OVER);

        // Start from OVER: new match with cleared scores
        btn_start = 1'b1; frames(5);
        chk("restart_state", int'(state_o), S_SERVE);
        chk("restart_sl", int'(score_left), 0);
        chk("restart_sr", int'(score_right), 0);
        chk("restart_reset", int'(ball_reset), 1);
        chk("restart_go", int'(game_over), 0);
        chk("restart_dir", int'(serve_dir), 0);
        btn_start = 1'b0; frames(5);
        frames(54);
        cycle(1'b1);
        chk("restart_play", int'(state_o), S_PLAY);

        // Left paddle miss: right scores, serve goes left
        miss(1'b1, 1'b0);
        chk("ml_sr", int'(score_right), 1);
        chk("ml_dir", int'(serve_dir), 0);
        to_play_from_point();
        miss(1'b0, 1'b1);
        chk("mr2_sl", int'(score_left), 1);
        chk("mr2_dir", int'(serve_dir), 1);
        to_play_from_point();

        // Pause, ignore misses, resume, pause again
        btn_start = 1'b1; frames(5);
        chk("pause_state", int'(state_o), S_PAUSE);
        chk("pause_run", int'(ball_run), 0);
        miss(1'b1, 1'b0);
        chk("pause_miss_sr", int'(score_right), 1);
        chk("pause_miss_state", int'(state_o), S_PAUSE);
        btn_start = 1'b0; frames(5);
        btn_start = 1'b1; frames(5);
        chk("resume_state", int'(state_o), S_PLAY);
        chk("resume_run", int'(ball_run), 1);
        btn_start = 1'b0; frames(5);
        btn_start = 1'b1; frames(5);
        chk("pause2_state", int'(state_o), S_PAUSE);

        // Synchronous reset aborts the match
        clr = 1'b1;
        btn_start = 1'b0;
        cycle(1'b0);
        chk("clr_state", int'(state_o), S_IDLE);
        chk("clr_sl", int'(score_left), 0);
        chk("clr_sr", int'(score_right), 0);
        chk("clr_dir", int'(serve_dir), 0);
        chk("clr_run", int'(ball_run), 0);
        chk("clr_reset", int'(ball_reset), 0);
        chk("clr_go", int'(game_over), 0);
        clr = 1'b0;
        frames(6);
        chk("post_clr_state", int'(state_o), S_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
